// File: rtl/boot_mem_subsystem_if.sv
// Bus bundle between the processor top level / core and boot_mem_subsystem.
// Carries the boot-load stream, run control, core instruction/data ports and
// status. clock and reset_n are kept as plain module ports.
//   slave  modport : used by boot_mem_subsystem (owns the memories)
//   master modport : used by whoever drives the loader stream and core side
// Parameters must match the ones given to boot_mem_subsystem.
interface boot_mem_subsystem_if #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int IRAM_DEPTH = 512
);
  localparam int IA_W = $clog2(IRAM_DEPTH);

  // boot loader stream
  logic              load_begin;
  logic              load_valid;
  logic              load_ready;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  // run control / status
  logic              start_req;
  logic              halt;
  logic              core_start;
  logic              busy;
  logic [IA_W:0]     words_loaded;
  logic              addr_fault;
  logic [DATA_W-1:0] load_csum;
  // core instruction port
  logic [ADDR_W-1:0] pc_in;
  logic              iram_rd_en;
  logic [DATA_W-1:0] iram_data;
  // core data port
  logic [ADDR_W-1:0] ar_in;
  logic              dram_rd_en;
  logic              dram_wr_en;
  logic [DATA_W-1:0] dram_wdata;
  logic [DATA_W-1:0] dram_rdata;

  modport slave (
    input  load_begin, load_valid, load_data, load_last,
    input  start_req, halt,
    input  pc_in, iram_rd_en,
    input  ar_in, dram_rd_en, dram_wr_en, dram_wdata,
    output load_ready, core_start, busy, words_loaded, addr_fault, load_csum,
    output iram_data, dram_rdata
  );

  modport master (
    output load_begin, load_valid, load_data, load_last,
    output start_req, halt,
    output pc_in, iram_rd_en,
    output ar_in, dram_rd_en, dram_wr_en, dram_wdata,
    input  load_ready, core_start, busy, words_loaded, addr_fault, load_csum,
    input  iram_data, dram_rdata
  );
endinterface

// File: rtl/boot_mem_subsystem.sv
// boot_mem_subsystem
// Owns the processor IRAM and DRAM arrays. A streaming boot loader fills IRAM
// over a valid/ready port, then the core is released with a one-cycle
// core_start pulse. Core accesses are range-checked; an out-of-range access
// reads as 0, drops writes and sets the sticky addr_fault flag.
// Ports:
//   clock    rising-edge clock
//   reset_n  synchronous active-low reset (arrays are not cleared)
//   bus      boot_mem_subsystem_if.slave: load stream, start/halt, core
//            pc/ar ports, status (busy, words_loaded, addr_fault, load_csum)
// Optional feature macro: BOOT_CSUM_EN
//   defined     -> load_csum is the XOR of all words accepted by the last load
//   not defined -> load_csum is tied to 0 and no checksum register exists
module boot_mem_subsystem #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int IRAM_DEPTH = 512,
  parameter int DRAM_DEPTH = 512
) (
  input logic                clock,
  input logic                reset_n,
  boot_mem_subsystem_if.slave bus
);
  localparam int IA_W = $clog2(IRAM_DEPTH);
  localparam int DA_W = $clog2(DRAM_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;
  localparam logic [1:0] ST_RUN   = 2'd3;

  localparam logic [ADDR_W-1:0] IRAM_LIMIT = ADDR_W'(IRAM_DEPTH);
  localparam logic [ADDR_W-1:0] DRAM_LIMIT = ADDR_W'(DRAM_DEPTH);
  localparam logic [IA_W:0]     LAST_IDX   = (IA_W+1)'(IRAM_DEPTH - 1);

  logic [1:0]        state;
  logic [IA_W:0]     load_count;
  logic              core_start_q;
  logic              addr_fault_q;
  logic [DATA_W-1:0] iram_q;
  logic [DATA_W-1:0] dram_q;

  logic [DATA_W-1:0] iram [IRAM_DEPTH];
  logic [DATA_W-1:0] dram [DRAM_DEPTH];

  logic in_load;
  logic in_run;
  logic xfer;
  logic load_done;
  logic enter_load;
  logic pc_bad;
  logic ar_bad;
  logic iram_rd;
  logic dram_rd;
  logic dram_wr;

  assign in_load    = (state == ST_LOAD);
  assign in_run     = (state == ST_RUN);
  assign xfer       = in_load & bus.load_valid;
  // Load ends on the flagged last word or when the final IRAM slot is filled,
  // so the pointer can never run past the array.
  assign load_done  = xfer & (bus.load_last | (load_count == LAST_IDX));
  assign enter_load = bus.load_begin & ((state == ST_IDLE) | (state == ST_READY));
  assign pc_bad     = (bus.pc_in >= IRAM_LIMIT);
  assign ar_bad     = (bus.ar_in >= DRAM_LIMIT);
  assign iram_rd    = in_run & bus.iram_rd_en;
  assign dram_rd    = in_run & bus.dram_rd_en;
  assign dram_wr    = in_run & bus.dram_wr_en;

  // Control FSM, load pointer (which is also the words_loaded count) and the
  // core_start pulse, which is high for the first RUN cycle only.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      load_count   <= '0;
      core_start_q <= 1'b0;
    end else begin
      core_start_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enter_load) begin
            state      <= ST_LOAD;
            load_count <= '0;
          end
        end
        ST_LOAD: begin
          if (xfer) load_count <= load_count + 1'b1;
          if (load_done) state <= ST_READY;
        end
        ST_READY: begin
          // A reload request wins over a simultaneous start request.
          if (enter_load) begin
            state      <= ST_LOAD;
            load_count <= '0;
          end else if (bus.start_req) begin
            state        <= ST_RUN;
            core_start_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.halt) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Registered core read data and the sticky range fault. Read registers hold
  // when not reading; an out-of-range read returns 0.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      addr_fault_q <= 1'b0;
      iram_q       <= '0;
      dram_q       <= '0;
    end else begin
      if (enter_load) begin
        addr_fault_q <= 1'b0;
      end else if ((iram_rd & pc_bad) | ((dram_rd | dram_wr) & ar_bad)) begin
        addr_fault_q <= 1'b1;
      end
      if (iram_rd) iram_q <= pc_bad ? '0 : iram[bus.pc_in[IA_W-1:0]];
      if (dram_rd) dram_q <= ar_bad ? '0 : dram[bus.ar_in[DA_W-1:0]];
    end
  end

  // Array writes carry no reset so contents survive reset. A same-cycle DRAM
  // read sees the old word because both sides are non-blocking.
  always_ff @(posedge clock) begin
    if (reset_n & xfer) iram[load_count[IA_W-1:0]] <= bus.load_data;
    if (reset_n & dram_wr & ~ar_bad) dram[bus.ar_in[DA_W-1:0]] <= bus.dram_wdata;
  end

`ifdef BOOT_CSUM_EN
  logic [DATA_W-1:0] csum_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      csum_q <= '0;
    end else if (enter_load) begin
      csum_q <= '0;
    end else if (xfer) begin
      csum_q <= csum_q ^ bus.load_data;
    end
  end

  assign bus.load_csum = csum_q;
`else
  assign bus.load_csum = '0;
`endif

  assign bus.load_ready   = in_load;
  assign bus.busy         = in_load | in_run;
  assign bus.core_start   = core_start_q;
  assign bus.words_loaded = load_count;
  assign bus.addr_fault   = addr_fault_q;
  assign bus.iram_data    = iram_q;
  assign bus.dram_rdata   = dram_q;
endmodule

// File: tb/tb_boot_mem_subsystem.sv
// Testbench for boot_mem_subsystem. Directed vectors are applied once per
// clock; each expectation is queued with the cycle it becomes due, and a
// monitor on the falling edge pops and compares due entries.
module tb_boot_mem_subsystem;
  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 16;
  localparam int IRAM_DEPTH = 512;
  localparam int DRAM_DEPTH = 512;

  localparam int SEL_IRAM  = 0;
  localparam int SEL_DRAM  = 1;
  localparam int SEL_WL    = 2;
  localparam int SEL_RDY   = 3;
  localparam int SEL_BUSY  = 4;
  localparam int SEL_START = 5;
  localparam int SEL_FAULT = 6;
  localparam int SEL_CSUM  = 7;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
    int          due;
  } sb_item_t;

  typedef struct packed {
    logic        reset_n, load_begin, load_valid;
    logic [15:0] load_data;
    logic        load_last, start_req, halt;
    logic [15:0] pc;
    logic        iram_rd;
    logic [15:0] ar;
    logic        dram_rd, dram_wr;
    logic [15:0] wdata;
  } stim_t;

  logic clock;
  logic reset_n;
  int   cycle;
  int   assert_count;
  int   fail_count;
  sb_item_t sb[$];

  boot_mem_subsystem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IRAM_DEPTH(IRAM_DEPTH)) bus();

  boot_mem_subsystem #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .IRAM_DEPTH(IRAM_DEPTH), .DRAM_DEPTH(DRAM_DEPTH)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cycle = 0;
  always @(posedge clock) cycle <= cycle + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.reset_n = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] actual_of(input int sel);
    case (sel)
      SEL_IRAM:  return 32'(bus.iram_data);
      SEL_DRAM:  return 32'(bus.dram_rdata);
      SEL_WL:    return 32'(bus.words_loaded);
      SEL_RDY:   return 32'(bus.load_ready);
      SEL_BUSY:  return 32'(bus.busy);
      SEL_START: return 32'(bus.core_start);
      SEL_FAULT: return 32'(bus.addr_fault);
      default:   return 32'(bus.load_csum);
    endcase
  endfunction

  task automatic drive(input stim_t s);
    reset_n        = s.reset_n;
    bus.load_begin = s.load_begin;
    bus.load_valid = s.load_valid;
    bus.load_data  = s.load_data;
    bus.load_last  = s.load_last;
    bus.start_req  = s.start_req;
    bus.halt       = s.halt;
    bus.pc_in      = s.pc;
    bus.iram_rd_en = s.iram_rd;
    bus.ar_in      = s.ar;
    bus.dram_rd_en = s.dram_rd;
    bus.dram_wr_en = s.dram_wr;
    bus.dram_wdata = s.wdata;
  endtask

  // Drives one vector just after a rising edge; it is sampled on the next one.
  task automatic applyStimulus(input stim_t s);
    @(posedge clock);
    #1;
    drive(s);
  endtask

  // Queue an expectation: lat=0 checks the present state, lat=1 the effect of
  // the vector just applied.
  task automatic expectOutput(input string name, input int sel, input logic [31:0] exp,
                              input int lat);
    sb_item_t it;
    it.name = name;
    it.sel  = sel;
    it.exp  = exp;
    it.due  = cycle + lat;
    sb.push_back(it);
  endtask

  task automatic checkOutput(input sb_item_t it);
    logic [31:0] act;
    act = actual_of(it.sel);
    assert_count++;
    if (act !== it.exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", it.name, act, it.exp, cycle);
    end
  endtask

  // Monitor: compare every queued expectation that is due this cycle.
  always @(negedge clock) begin
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due == cycle) begin
        checkOutput(sb[i]);
        sb.delete(i);
      end else if (sb[i].due < cycle) begin
        assert_count++;
        fail_count++;
        $display("[TB] FAIL %s: got unchecked expected check at cycle %0d", sb[i].name, sb[i].due);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    stim_t v;
    logic [15:0] words [4];
    logic [15:0] csum;
    logic [15:0] first_word;
    logic [15:0] last_word;
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h4444; words[3] = 16'h8888;
    assert_count = 0;
    fail_count   = 0;

    // Reset state
    v = idle(); v.reset_n = 1'b0;
    drive(v);
    applyStimulus(v);
    applyStimulus(v);
    expectOutput("rst_ready", SEL_RDY,   0, 0);
    expectOutput("rst_busy",  SEL_BUSY,  0, 0);
    expectOutput("rst_wl",    SEL_WL,    0, 0);
    expectOutput("rst_start", SEL_START, 0, 0);
    expectOutput("rst_fault", SEL_FAULT, 0, 0);
    expectOutput("rst_csum",  SEL_CSUM,  0, 0);
    expectOutput("rst_iram",  SEL_IRAM,  0, 0);
    expectOutput("rst_dram",  SEL_DRAM,  0, 0);

    // Four-word load ending on load_last
    v = idle(); v.load_begin = 1'b1; applyStimulus(v);
    expectOutput("load_ready_up", SEL_RDY,  1, 1);
    expectOutput("load_busy",     SEL_BUSY, 1, 1);
    for (int i = 0; i < 4; i++) begin
      v = idle(); v.load_valid = 1'b1; v.load_data = words[i]; v.load_last = (i == 3);
      applyStimulus(v);
    end
    expectOutput("load4_ready", SEL_RDY,  0, 1);
    expectOutput("load4_wl",    SEL_WL,   4, 1);
    expectOutput("load4_busy",  SEL_BUSY, 0, 1);
`ifdef BOOT_CSUM_EN
    expectOutput("load4_csum",  SEL_CSUM, 32'hFFFF, 1);
`else
    expectOutput("load4_csum",  SEL_CSUM, 0, 1);
`endif

    // Start pulse and first instruction fetch
    v = idle(); v.start_req = 1'b1; applyStimulus(v);
    expectOutput("start_pulse", SEL_START, 1, 1);
    expectOutput("run_busy",    SEL_BUSY,  1, 1);
    expectOutput("start_drop",  SEL_START, 0, 2);
    v = idle(); v.iram_rd = 1'b1; v.pc = 16'd2; applyStimulus(v);
    expectOutput("fetch_pc2", SEL_IRAM, 32'h4444, 1);

    // DRAM read-before-write
    v = idle(); v.dram_wr = 1'b1; v.ar = 16'd5; v.wdata = 16'h0000; applyStimulus(v);
    v = idle(); v.dram_wr = 1'b1; v.dram_rd = 1'b1; v.ar = 16'd5; v.wdata = 16'hBEEF;
    applyStimulus(v);
    expectOutput("rbw_old", SEL_DRAM, 0, 1);
    v = idle(); v.dram_rd = 1'b1; v.ar = 16'd5; applyStimulus(v);
    expectOutput("rbw_new", SEL_DRAM, 32'hBEEF, 1);

    // Out-of-range accesses
    v = idle(); v.iram_rd = 1'b1; v.pc = 16'd600; applyStimulus(v);
    expectOutput("pc600_data",  SEL_IRAM,  0, 1);
    expectOutput("pc600_fault", SEL_FAULT, 1, 1);
    v = idle(); v.dram_wr = 1'b1; v.ar = 16'd88; v.wdata = 16'h1234; applyStimulus(v);
    v = idle(); v.dram_wr = 1'b1; v.ar = 16'd600; v.wdata = 16'hDEAD; applyStimulus(v);
    v = idle(); v.dram_rd = 1'b1; v.ar = 16'd88; applyStimulus(v);
    expectOutput("oor_wr_dropped", SEL_DRAM, 32'h1234, 1);
    v = idle(); v.dram_rd = 1'b1; v.ar = 16'd700; applyStimulus(v);
    expectOutput("oor_rd_zero", SEL_DRAM, 0, 1);

    // Halt; fault stays; core ports ignored outside RUN
    v = idle(); v.halt = 1'b1; applyStimulus(v);
    expectOutput("halt_busy",   SEL_BUSY,  0, 1);
    expectOutput("fault_stick", SEL_FAULT, 1, 1);
    v = idle(); v.iram_rd = 1'b1; v.pc = 16'd0; v.dram_rd = 1'b1; v.dram_wr = 1'b1;
    v.ar = 16'd88; v.wdata = 16'h5555; applyStimulus(v);
    expectOutput("idle_iram_hold", SEL_IRAM, 0, 1);
    expectOutput("idle_dram_hold", SEL_DRAM, 0, 1);

    // Full-depth stream without load_last
    v = idle(); v.load_begin = 1'b1; applyStimulus(v);
    expectOutput("reload_fault_clr", SEL_FAULT, 0, 1);
    expectOutput("reload_wl_clr",    SEL_WL,    0, 1);
    csum = '0;
    first_word = '0;
    last_word  = '0;
    for (int i = 0; i < IRAM_DEPTH; i++) begin
      v = idle(); v.load_valid = 1'b1; v.load_data = 16'(i * 7 + 256);
      applyStimulus(v);
      csum = csum ^ v.load_data;
      if (i == 0) first_word = v.load_data;
      if (i == IRAM_DEPTH - 1) last_word = v.load_data;
      if (i == IRAM_DEPTH - 2) expectOutput("stream_ready_511", SEL_RDY, 1, 1);
    end
    expectOutput("stream_ready_drop", SEL_RDY,  0, 1);
    expectOutput("stream_wl",         SEL_WL,   32'(IRAM_DEPTH), 1);
    expectOutput("stream_busy",       SEL_BUSY, 0, 1);
`ifdef BOOT_CSUM_EN
    expectOutput("stream_csum", SEL_CSUM, 32'(csum), 1);
`else
    expectOutput("stream_csum", SEL_CSUM, 0, 1);
`endif
    v = idle(); v.load_valid = 1'b1; v.load_data = 16'hFFFF; applyStimulus(v);
    expectOutput("no_xfer_past_depth", SEL_WL, 32'(IRAM_DEPTH), 1);
    v = idle(); v.start_req = 1'b1; applyStimulus(v);
    v = idle(); v.iram_rd = 1'b1; v.pc = 16'(IRAM_DEPTH - 1); applyStimulus(v);
    expectOutput("fetch_last", SEL_IRAM, 32'(last_word), 1);
    v = idle(); v.iram_rd = 1'b1; v.pc = 16'd0; applyStimulus(v);
    expectOutput("fetch_first", SEL_IRAM, 32'(first_word), 1);
    v = idle(); v.dram_rd = 1'b1; v.ar = 16'd88; applyStimulus(v);
    expectOutput("idle_wr_ignored", SEL_DRAM, 32'h1234, 1);
    v = idle(); v.halt = 1'b1; applyStimulus(v);

    // Reset during a load
    v = idle(); v.load_begin = 1'b1; applyStimulus(v);
    for (int i = 0; i < 3; i++) begin
      v = idle(); v.load_valid = 1'b1; v.load_data = 16'hA001 + 16'(i); applyStimulus(v);
    end
    expectOutput("partial_wl", SEL_WL, 3, 1);
    v = idle(); v.reset_n = 1'b0; applyStimulus(v);
    expectOutput("abort_ready", SEL_RDY,  0, 1);
    expectOutput("abort_wl",    SEL_WL,   0, 1);
    expectOutput("abort_busy",  SEL_BUSY, 0, 1);
    expectOutput("abort_csum",  SEL_CSUM, 0, 1);
    v = idle(); applyStimulus(v);
    v = idle(); v.load_begin = 1'b1; applyStimulus(v);
    v = idle(); v.load_valid = 1'b1; v.load_data = 16'hB000; v.load_last = 1'b1; applyStimulus(v);
    expectOutput("short_wl", SEL_WL, 1, 1);
    v = idle(); v.start_req = 1'b1; applyStimulus(v);
    v = idle(); v.iram_rd = 1'b1; v.pc = 16'd1; applyStimulus(v);
    expectOutput("retain_1", SEL_IRAM, 32'hA002, 1);
    v = idle(); v.iram_rd = 1'b1; v.pc = 16'd2; applyStimulus(v);
    expectOutput("retain_2", SEL_IRAM, 32'hA003, 1);
    v = idle(); v.iram_rd = 1'b1; v.pc = 16'd0; applyStimulus(v);
    expectOutput("reload_0", SEL_IRAM, 32'hB000, 1);
    v = idle(); v.halt = 1'b1; applyStimulus(v);

    for (int i = 0; i < 4; i++) applyStimulus(idle());
    while (sb.size() > 0) begin
      assert_count++;
      fail_count++;
      $display("[TB] FAIL %s: got unchecked expected check at cycle %0d", sb[0].name, sb[0].due);
      void'(sb.pop_front());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end
endmodule
